// File: rtl/uart_cmd_counter_if.sv
// RX FIFO read-port bundle between the FIFO (master) and the command counter (slave).
// rx_data is first-word-fall-through: valid whenever rx_empty is low.
interface uart_cmd_counter_if;
   logic       rx_empty;
   logic [7:0] rx_data;
   logic       rx_pop;

   modport master (output rx_empty, output rx_data, input rx_pop);
   modport slave  (input rx_empty, input rx_data, output rx_pop);
endinterface

// File: rtl/uart_cmd_counter.sv
// Command-driven 0..9999 up/down counter for the FND display path.
// Pops ASCII commands from the RX FIFO (R=run toggle, C=clear, M=mode toggle) and paces counting with a prescaler.
module uart_cmd_counter #(
   parameter int TICK_DIV = 10_000_000
) (
   input  logic               clk,
   input  logic               rst,
   uart_cmd_counter_if.slave  rx,
   output logic [13:0]        counter,
   output logic               run,
   output logic               mode_down,
   output logic               cmd_err
);

   localparam int              PW   = $clog2(TICK_DIV);
   localparam logic [PW-1:0]   PMAX = PW'(TICK_DIV - 1);
   localparam logic [13:0]     CMAX = 14'd9999;

   typedef enum logic [1:0] {IDLE, EXEC, GAP} state_t;

   state_t        state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic          pop_q, pop_d;
   logic          run_tgl_q, run_tgl_d;
   logic          mode_tgl_q, mode_tgl_d;
   logic          clr_q, clr_d;
   logic          err_q, err_d;
   logic [13:0]   cnt_q, cnt_d;
   logic          run_q, run_d;
   logic          mode_q, mode_d;
   logic          cmd_err_q, cmd_err_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;

   function automatic logic [7:0] to_upper(input logic [7:0] c);
      return c & 8'hDF;
   endfunction

   function automatic logic [13:0] next_count(input logic [13:0] c, input logic down);
      if (down) return (c == 14'd0) ? CMAX : c - 14'd1;
      else      return (c == CMAX)  ? 14'd0 : c + 14'd1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cmd_q      <= 8'h00;
         pop_q      <= 1'b0;
         run_tgl_q  <= 1'b0;
         mode_tgl_q <= 1'b0;
         clr_q      <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= 14'd0;
         run_q      <= 1'b0;
         mode_q     <= 1'b0;
         cmd_err_q  <= 1'b0;
         presc_q    <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         pop_q      <= pop_d;
         run_tgl_q  <= run_tgl_d;
         mode_tgl_q <= mode_tgl_d;
         clr_q      <= clr_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         run_q      <= run_d;
         mode_q     <= mode_d;
         cmd_err_q  <= cmd_err_d;
         presc_q    <= presc_d;
      end
   end

   // EXEC registers one-cycle command strobes; the datapath applies them on the following edge.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      pop_d      = 1'b0;
      run_tgl_d  = 1'b0;
      mode_tgl_d = 1'b0;
      clr_d      = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx.rx_empty) begin
               cmd_d   = rx.rx_data;
               pop_d   = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            case (to_upper(cmd_q))
               8'h52:   run_tgl_d  = 1'b1;
               8'h43:   clr_d      = 1'b1;
               8'h4D:   mode_tgl_d = 1'b1;
               default: err_d      = 1'b1;
            endcase
            state_d = GAP;
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Tick uses the pre-update run/mode; clear overrides both counter and prescaler.
   always_comb begin
      tick      = run_q && (presc_q == PMAX);
      presc_d   = presc_q;
      cnt_d     = cnt_q;
      if (run_q) presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick)  cnt_d   = next_count(cnt_q, mode_q);
      if (clr_q) begin
         cnt_d   = 14'd0;
         presc_d = '0;
      end
      run_d     = run_q ^ run_tgl_q;
      mode_d    = mode_q ^ mode_tgl_q;
      cmd_err_d = err_q;
   end

   assign rx.rx_pop = pop_q;
   assign counter   = cnt_q;
   assign run       = run_q;
   assign mode_down = mode_q;
   assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_counter.sv
// Directed bench for uart_cmd_counter with TICK_DIV=4 and a small FWFT FIFO model.
module tb_uart_cmd_counter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [13:0] counter;
   logic        run, mode_down, cmd_err;

   uart_cmd_counter_if ifc();

   uart_cmd_counter #(.TICK_DIV(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (ifc.slave),
      .counter   (counter),
      .run       (run),
      .mode_down (mode_down),
      .cmd_err   (cmd_err)
   );

   always #5 clk = ~clk;

   logic [7:0] fifo_mem [16];
   int rd = 0, wr = 0;
   assign ifc.rx_empty = (rd == wr);
   assign ifc.rx_data  = fifo_mem[rd % 16];

   int   cyc = 0, pop_n = 0, err_n = 0, dbl_pop = 0, bad_pop = 0;
   int   pop_t [64];
   int   err_t [64];
   logic prev_pop = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ifc.rx_pop) begin
         if (pop_n < 64) pop_t[pop_n] <= cyc;
         pop_n <= pop_n + 1;
         if (rd != wr) rd <= rd + 1;
         else          bad_pop <= bad_pop + 1;
      end
      if (cmd_err) begin
         if (err_n < 64) err_t[err_n] <= cyc;
         err_n <= err_n + 1;
      end
      if (ifc.rx_pop && prev_pop) dbl_pop <= dbl_pop + 1;
      prev_pop <= ifc.rx_pop;
   end

   int total = 0, bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo_mem[wr % 16] = b;
      wr = wr + 1;
   endtask

   task automatic send(input logic [7:0] b);
      push(b);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int p0, e0, k;

      // reset held from time zero
      repeat (2) @(negedge clk);
      check("rst_counter", 32'(counter), 0);
      check("rst_run", 32'(run), 0);
      check("rst_mode", 32'(mode_down), 0);
      check("rst_pop", 32'(ifc.rx_pop), 0);
      check("rst_err", 32'(cmd_err), 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_no_pop", 32'(pop_n), 0);

      // start counting
      push(8'h72);
      @(negedge clk);
      check("pop_strobe", 32'(ifc.rx_pop), 1);
      repeat (2) @(negedge clk);
      check("run_on", 32'(run), 1);
      check("one_pop", 32'(pop_n), 1);
      check("cnt_start", 32'(counter), 0);
      repeat (40) @(negedge clk);
      check("cnt_40cyc", 32'(counter), 10);

      // stop, hold, resume with preserved prescaler phase
      send(8'h52);
      check("run_off", 32'(run), 0);
      check("cnt_stop", 32'(counter), 10);
      repeat (20) @(negedge clk);
      check("cnt_frozen", 32'(counter), 10);
      send(8'h72);
      check("run_resume", 32'(run), 1);
      check("cnt_resume0", 32'(counter), 10);
      @(negedge clk);
      check("phase_kept", 32'(counter), 11);
      repeat (4) @(negedge clk);
      check("cnt_12", 32'(counter), 12);

      // wrap down then up
      send(8'h52);
      check("run_off2", 32'(run), 0);
      send(8'h63);
      check("clear", 32'(counter), 0);
      send(8'h6D);
      check("mode_down", 32'(mode_down), 1);
      send(8'h72);
      check("cnt_pre_wrap", 32'(counter), 0);
      repeat (4) @(negedge clk);
      check("wrap_down", 32'(counter), 9999);
      repeat (4) @(negedge clk);
      check("down_9998", 32'(counter), 9998);
      send(8'h6D);
      check("mode_up", 32'(mode_down), 0);
      check("cnt_hold_9998", 32'(counter), 9998);
      @(negedge clk);
      check("up_9999", 32'(counter), 9999);
      repeat (4) @(negedge clk);
      check("wrap_up", 32'(counter), 0);

      // clear lands on a tick edge
      @(negedge clk);
      send(8'h43);
      check("clr_wins", 32'(counter), 0);
      repeat (3) @(negedge clk);
      check("clr_no_early", 32'(counter), 0);
      @(negedge clk);
      check("clr_next_inc", 32'(counter), 1);
      send(8'h52);
      check("run_off3", 32'(run), 0);

      // back-to-back bytes
      p0 = pop_n;
      e0 = err_n;
      push(8'h6D);
      push(8'h78);
      push(8'h4D);
      repeat (15) @(negedge clk);
      check("b2b_pops", 32'(pop_n - p0), 3);
      check("b2b_gap1", 32'(pop_t[p0 + 1] - pop_t[p0]), 3);
      check("b2b_gap2", 32'(pop_t[p0 + 2] - pop_t[p0 + 1]), 3);
      check("b2b_err", 32'(err_n - e0), 1);
      check("err_timing", 32'(err_t[e0] - pop_t[p0 + 1]), 2);
      check("b2b_mode", 32'(mode_down), 0);

      // idle FIFO
      p0 = pop_n;
      e0 = err_n;
      repeat (1000) @(negedge clk);
      check("idle_pops", 32'(pop_n - p0), 0);
      check("idle_errs", 32'(err_n - e0), 0);
      check("no_dbl_pop", 32'(dbl_pop), 0);
      check("no_empty_pop", 32'(bad_pop), 0);

      // asynchronous reset mid-count
      send(8'h63);
      send(8'h72);
      k = 0;
      while (counter != 14'd37 && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("reach_37", 32'(counter), 37);
      #2 rst = 1'b0;
      #1;
      check("arst_counter", 32'(counter), 0);
      check("arst_run", 32'(run), 0);
      check("arst_mode", 32'(mode_down), 0);
      check("arst_pop", 32'(ifc.rx_pop), 0);
      check("arst_err", 32'(cmd_err), 0);
      @(negedge clk);
      rst = 1'b1;
      p0 = pop_n;
      repeat (10) @(negedge clk);
      check("post_rst_pops", 32'(pop_n - p0), 0);
      check("post_rst_cnt", 32'(counter), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
